// File: rtl/miner_pkg.sv
// Shared definitions for the miner comm-side blocks.
//   NONCE_W     : width of one golden-nonce word.
//   ACK_TIMEOUT : cycles the TX FSM waits for serial_busy to rise before
//                 treating the word as sent.
//   tx_state_e  : nonce_queue transmit FSM states.
package miner_pkg;

    localparam int unsigned NONCE_W     = 32;
    localparam int unsigned ACK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StSend     = 2'd1,
        StWaitAck  = 2'd2,
        StWaitDone = 2'd3
    } tx_state_e;

endpackage

// File: rtl/nonce_queue_if.sv
// UART TX handshake between nonce_queue and serial_core.
//   serial_send  : one-cycle transmit request (queue -> UART)
//   golden_nonce : word to transmit, stable until the UART finishes
//   serial_busy  : UART transmitter busy (UART -> queue)
// master = nonce_queue side, slave = UART side.
interface nonce_queue_if;
    import miner_pkg::*;

    logic               serial_send;
    logic               serial_busy;
    logic [NONCE_W-1:0] golden_nonce;

    modport master (output serial_send, output golden_nonce, input serial_busy);
    modport slave  (input serial_send, input golden_nonce, output serial_busy);
endinterface

// File: rtl/nonce_fifo.sv
// Circular FIFO of nonce words with a registered read port.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : empties the FIFO (pointers and count) in one cycle
//   wr_en/wr_data: push; ignored when full unless a pop happens the same cycle
//   rd_en        : pop; rd_data is loaded at the clock edge and then held
//   full, empty  : occupancy flags; count : current occupancy
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [NONCE_W-1:0]   wr_data,
    input  logic                 rd_en,
    output logic [NONCE_W-1:0]   rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count
);

    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    logic [NONCE_W-1:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_BITS:0]   count_q;
    logic [NONCE_W-1:0]   rd_data_q;
    logic                 do_wr, do_rd;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rd_data = rd_data_q;

    assign do_rd = rd_en & ~clr & ~empty;
    assign do_wr = wr_en & ~clr & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + ADDR_BITS'(1);
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + ADDR_BITS'(1);
                rd_data_q <= mem[rd_ptr_q];
            end
            if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
            else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/nonce_queue.sv
// Golden-nonce queue between the hashcore array and the UART transmitter.
// Each slave strobe is captured into a pending slot, slots are drained
// round-robin into a FIFO, and a small FSM feeds the UART one word at a time.
// Ports:
//   clk, reset_n  : comm clock, synchronous active-low reset
//   new_nonces    : per-slave one-cycle strobe
//   slave_nonces  : per-slave nonce, slave i at [32*i+31:32*i]
//   flush         : new work; empties queue and pending slots
//   tx            : UART handshake (serial_send, golden_nonce, serial_busy)
//   queue_count   : FIFO occupancy; overflow : sticky dropped-nonce flag
// Build option: NONCE_QUEUE_DEDUP_EN drops a winner equal to the last
// enqueued word (no overflow).
module nonce_queue
    import miner_pkg::*;
#(
    parameter int unsigned SLAVES    = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [SLAVES-1:0]           new_nonces,
    input  logic [NONCE_W*SLAVES-1:0]   slave_nonces,
    input  logic                        flush,
    nonce_queue_if.master               tx,
    output logic [ADDR_BITS:0]          queue_count,
    output logic                        overflow
);

    localparam int unsigned PTR_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT);

    logic [SLAVES-1:0]              pend_flag_q, pend_flag_d;
    logic [SLAVES-1:0][NONCE_W-1:0] pend_data_q, pend_data_d;
    logic [PTR_W-1:0]               rr_ptr_q, rr_ptr_d, win_idx;
    logic                           overflow_q, overflow_d;
    logic                           win_found, enq, dup;
    logic [NONCE_W-1:0]             win_data, fifo_rd_data;
    logic                           fifo_rd, fifo_full, fifo_empty;
    tx_state_e                      state_q, state_d;
    logic [ACK_W-1:0]               ack_cnt_q, ack_cnt_d;
    int unsigned                    idx;

    // Round-robin search starting at the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < SLAVES; i++) begin
            idx = (32'(rr_ptr_q) + i) % SLAVES;
            if (!win_found && pend_flag_q[PTR_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign win_data = pend_data_q[win_idx];
    assign enq      = win_found & ~fifo_full & ~flush;

`ifdef NONCE_QUEUE_DEDUP_EN
    logic               last_valid_q;
    logic [NONCE_W-1:0] last_q;

    assign dup = last_valid_q & (win_data == last_q);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_valid_q <= 1'b0;
            last_q       <= '0;
        end else if (flush) begin
            last_valid_q <= 1'b0;
        end else if (enq && !dup) begin
            last_valid_q <= 1'b1;
            last_q       <= win_data;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Slot update: a coincident strobe beats the enqueue clear, and only
    // counts as a drop when the old word was not taken this cycle.
    always_comb begin
        pend_flag_d = pend_flag_q;
        pend_data_d = pend_data_q;
        overflow_d  = overflow_q;
        rr_ptr_d    = rr_ptr_q;
        if (enq) begin
            rr_ptr_d = (32'(win_idx) == SLAVES - 1) ? '0 : win_idx + PTR_W'(1);
        end
        for (int unsigned s = 0; s < SLAVES; s++) begin
            if (flush) begin
                pend_flag_d[s] = 1'b0;
            end else if (new_nonces[s]) begin
                pend_flag_d[s] = 1'b1;
                pend_data_d[s] = slave_nonces[NONCE_W*s +: NONCE_W];
                if (pend_flag_q[s] && !(enq && 32'(win_idx) == s)) overflow_d = 1'b1;
            end else if (enq && 32'(win_idx) == s) begin
                pend_flag_d[s] = 1'b0;
            end
        end
    end

    // TX FSM next state.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        fifo_rd   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !tx.serial_busy && !flush) begin
                    fifo_rd = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                state_d   = StWaitAck;
                ack_cnt_d = '0;
            end
            StWaitAck: begin
                if (tx.serial_busy) begin
                    state_d = StWaitDone;
                end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_d = StIdle;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx.serial_busy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_flag_q <= '0;
            pend_data_q <= '0;
            rr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            state_q     <= StIdle;
            ack_cnt_q   <= '0;
        end else begin
            pend_flag_q <= pend_flag_d;
            pend_data_q <= pend_data_d;
            rr_ptr_q    <= rr_ptr_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            ack_cnt_q   <= ack_cnt_d;
        end
    end

    nonce_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .wr_en   (enq & ~dup),
        .wr_data (win_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (queue_count)
    );

    // golden_nonce is the FIFO read register: it only changes on a pop,
    // so it stays stable for the whole transmission and across a flush.
    assign tx.serial_send  = (state_q == StSend);
    assign tx.golden_nonce = fifo_rd_data;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_nonce_queue.sv
module tb_nonce_queue;
    import miner_pkg::*;

    localparam int SLAVES    = 2;
    localparam int DEPTH     = 8;
    localparam int ADDR_BITS = 3;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [SLAVES-1:0]         new_nonces;
    logic [32*SLAVES-1:0]      slave_nonces;
    logic                      flush;
    logic [ADDR_BITS:0]        queue_count;
    logic                      overflow;

    nonce_queue_if tx_if();

    always #5 clk = ~clk;

    nonce_queue #(
        .SLAVES    (SLAVES),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_nonces   (new_nonces),
        .slave_nonces (slave_nonces),
        .flush        (flush),
        .tx           (tx_if),
        .queue_count  (queue_count),
        .overflow     (overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [31:0] tx_log[$];
    int          send_cyc[$];

    // UART responder
    bit resp_en, resp_noack, rand_resp, pend_ack;
    int busy_len, busy_left;

    // Reference model: pending slots, queue of words, simple TX sequencer
    typedef enum {MIdle, MSend, MAck, MDone} mtx_e;
    bit          m_pf[SLAVES];
    logic [31:0] m_pd[SLAVES];
    logic [31:0] m_q[$];
    int          m_ptr;
    bit          m_ovf;
    mtx_e        m_tx;
    int          m_ack_left;
    logic [31:0] m_cur;
    bit          m_last_v;
    logic [31:0] m_last;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        for (int s = 0; s < SLAVES; s++) begin
            m_pf[s] = 0;
            m_pd[s] = '0;
        end
        m_q.delete();
        m_ptr = 0; m_ovf = 0; m_tx = MIdle; m_ack_left = 0;
        m_cur = '0; m_last_v = 0; m_last = '0;
    endtask

    task automatic model_tick();
        bit          busy, full_pre;
        int          w;
        logic [31:0] wd;
        busy     = tx_if.serial_busy;
        full_pre = (m_q.size() == DEPTH);
        w        = -1;
        case (m_tx)
            MIdle: if (m_q.size() != 0 && !busy && !flush) begin
                m_cur = m_q.pop_front();
                m_tx  = MSend;
            end
            MSend: begin m_tx = MAck; m_ack_left = ACK_TIMEOUT; end
            MAck: begin
                if (busy) m_tx = MDone;
                else begin
                    m_ack_left--;
                    if (m_ack_left == 0) m_tx = MIdle;
                end
            end
            MDone: if (!busy) m_tx = MIdle;
        endcase
        if (flush) begin
            m_q.delete();
            m_last_v = 0;
        end else if (!full_pre) begin
            for (int i = 0; i < SLAVES; i++)
                if (w < 0 && m_pf[(m_ptr + i) % SLAVES]) w = (m_ptr + i) % SLAVES;
            if (w >= 0) begin
                wd    = m_pd[w];
                m_ptr = (w + 1) % SLAVES;
`ifdef NONCE_QUEUE_DEDUP_EN
                if (!(m_last_v && wd == m_last)) begin
                    m_q.push_back(wd);
                    m_last   = wd;
                    m_last_v = 1;
                end
`else
                m_q.push_back(wd);
`endif
            end
        end
        for (int s = 0; s < SLAVES; s++) begin
            if (flush) m_pf[s] = 0;
            else if (new_nonces[s]) begin
                if (m_pf[s] && s != w) m_ovf = 1;
                m_pf[s] = 1;
                m_pd[s] = slave_nonces[32*s +: 32];
            end else if (s == w) m_pf[s] = 0;
        end
    endtask

    task automatic check_outputs();
        chk("queue_count",  32'(queue_count), 32'(m_q.size()));
        chk("overflow",     32'(overflow), 32'(m_ovf));
        chk("serial_send",  32'(tx_if.serial_send), 32'(m_tx == MSend));
        chk("golden_nonce", tx_if.golden_nonce, m_cur);
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        if (tx_if.serial_send) begin
            tx_log.push_back(tx_if.golden_nonce);
            send_cyc.push_back(cyc);
        end
        new_nonces = '0;
        flush      = 1'b0;
        if (resp_en) begin
            if (pend_ack) begin
                pend_ack  = 0;
                busy_left = busy_len;
            end
            tx_if.serial_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if (m_tx == MSend) begin
                if (rand_resp) begin
                    resp_noack = ($urandom_range(0, 7) == 0);
                    busy_len   = $urandom_range(1, 6);
                end
                if (!resp_noack) pend_ack = 1;
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic strobe(int s, logic [31:0] v);
        new_nonces[s]          = 1'b1;
        slave_nonces[32*s +: 32] = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; new_nonces = '0; flush = 1'b0; slave_nonces = '0;
        tx_if.serial_busy = 1'b0;
        resp_en = 0; resp_noack = 0; rand_resp = 0; pend_ack = 0;
        busy_left = 0; busy_len = 5;
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        cyc = 0;
        check_outputs();
        tx_log.delete();
        send_cyc.delete();
    endtask

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] n0;
        logic [31:0] n1;
        int          exp_n;
        logic [31:0] e0;
        logic [31:0] e1;
        int          blen;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] exp_words[$];
    int          exp_dedup;
    int          tries;

    initial begin
        vecs[0] = '{2'b01, 32'hDEADBEEF, 32'h0,        1, 32'hDEADBEEF, 32'h0,        40};
        vecs[1] = '{2'b11, 32'h00000011, 32'h80000022, 2, 32'h00000011, 32'h80000022, 5};
        vecs[2] = '{2'b10, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 32'h0,        3};
        vecs[3] = '{2'b11, 32'h0,        32'hFFFFFFFF, 2, 32'h0,        32'hFFFFFFFF, 1};

        // Single-cycle strobe patterns from reset
        foreach (vecs[v]) begin
            do_reset();
            resp_en  = 1;
            busy_len = vecs[v].blen;
            new_nonces   = vecs[v].mask;
            slave_nonces = {vecs[v].n1, vecs[v].n0};
            step();
            run(150);
            chk("vec_tx_count", tx_log.size(), vecs[v].exp_n);
            if (tx_log.size() > 0) begin
                chk("vec_word0", tx_log[0], vecs[v].e0);
                chk("vec_latency", send_cyc[0], 3);
            end
            if (tx_log.size() > 1) chk("vec_word1", tx_log[1], vecs[v].e1);
            chk("vec_golden_held", tx_if.golden_nonce,
                (vecs[v].exp_n == 2) ? vecs[v].e1 : vecs[v].e0);
            chk("vec_count_zero", 32'(queue_count), 0);
            chk("vec_no_overflow", 32'(overflow), 0);
        end

        // Fill to capacity with UART busy, then overflow one slot
        do_reset();
        tx_if.serial_busy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            strobe(k % 2, 32'h100 + k);
            step();
        end
        run(2);
        chk("fill_count", 32'(queue_count), 8);
        chk("fill_no_overflow", 32'(overflow), 0);
        strobe(0, 32'h1FF);
        step();
        chk("fill_overflow", 32'(overflow), 1);
        tx_log.delete();
        resp_en  = 1;
        busy_len = 3;
        run(300);
        exp_words.delete();
        for (int k = 0; k < 8; k++) exp_words.push_back(32'h100 + k);
        exp_words.push_back(32'h1FF);
        exp_words.push_back(32'h109);
        chk("drain_count", tx_log.size(), exp_words.size());
        foreach (exp_words[k])
            if (k < tx_log.size()) chk("drain_order", tx_log[k], exp_words[k]);

        // Flush while the first word is in WAIT_DONE
        do_reset();
        tx_if.serial_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            strobe(k % 2, 32'h200 + k);
            step();
        end
        run(3);
        chk("flush_pre_count", 32'(queue_count), 4);
        resp_en  = 1;
        busy_len = 20;
        tries    = 0;
        while (tx_log.size() == 0 && tries < 20) begin
            step();
            tries++;
        end
        chk("flush_send_seen", tx_log.size(), 1);
        run(2);
        chk("flush_mid_count", 32'(queue_count), 3);
        flush = 1'b1;
        step();
        chk("flush_count_zero", 32'(queue_count), 0);
        run(80);
        chk("flush_no_more_sends", tx_log.size(), 1);
        chk("flush_golden", tx_if.golden_nonce, 32'h200);
        chk("flush_overflow", 32'(overflow), 0);

        // UART never acknowledges
        do_reset();
        resp_en    = 1;
        resp_noack = 1;
        new_nonces   = 2'b11;
        slave_nonces = {32'h301, 32'h300};
        step();
        run(30);
        chk("timeout_sends", tx_log.size(), 2);
        if (send_cyc.size() > 1) begin
            chk("timeout_first", send_cyc[0], 3);
            chk("timeout_second", send_cyc[1], 9);
            chk("timeout_word", tx_log[1], 32'h301);
        end

        // Repeated nonce on one slave
        do_reset();
        resp_en  = 1;
        busy_len = 3;
        strobe(1, 32'h12345678);
        step();
        run(2);
        strobe(1, 32'h12345678);
        step();
        run(60);
`ifdef NONCE_QUEUE_DEDUP_EN
        exp_dedup = 1;
`else
        exp_dedup = 2;
`endif
        chk("dedup_sends", tx_log.size(), exp_dedup);

        // Random traffic against the model
        do_reset();
        resp_en   = 1;
        rand_resp = 1;
        for (int c = 0; c < 2500; c++) begin
            for (int s = 0; s < SLAVES; s++) begin
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 2))
                        0: strobe(s, 32'hA5A5A5A5);
                        1: strobe(s, 32'h5A5A5A5A);
                        default: strobe(s, $urandom);
                    endcase
                end
            end
            if ($urandom_range(0, 99) == 0) flush = 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
